booth_ctrl: RTL and testbench



---
 rtl/booth_ctrl.sv | 169 ++++++++++++++++
 tb/tb_booth_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// booth_ctrl: control FSM for an 8-bit radix-2 Booth multiplier datapath.
// Optional BOOTH_SKIP_EN: shift inside EVAL on 00/11 pairs, skipping SHIFT.
module booth_ctrl #(
  parameter logic [3:0] CNT_INIT = 4'd8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic busy,
  input  logic eqz,
  input  logic q0,
  input  logic qm1,
  output logic ldA,
  output logic shiftA,
  output logic clrA,
  output logic ldQ,
  output logic shiftQ,
  output logic clrQ,
  output logic clrff,
  output logic ldM,
  output logic addsub,
  output logic ldcnt,
  output logic decr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LDQ   = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic st_idle;
  logic st_ldq;
  logic st_eval;
  logic st_shift;
  logic st_done;

  assign st_idle  = (state_q == S_IDLE);
  assign st_ldq   = (state_q == S_LDQ);
  assign st_eval  = (state_q == S_EVAL);
  assign st_shift = (state_q == S_SHIFT);
  assign st_done  = (state_q == S_DONE);

  assign in_ready  = st_idle | st_ldq;
  assign busy      = ~st_idle;
  assign out_valid = st_done;

  always_comb begin
    state_d = state_q;
    ldA     = 1'b0;
    shiftA  = 1'b0;
    clrA    = 1'b0;
    ldQ     = 1'b0;
    shiftQ  = 1'b0;
    clrQ    = 1'b0;
    clrff   = 1'b0;
    ldM     = 1'b0;
    addsub  = 1'b0;
    ldcnt   = 1'b0;
    decr    = 1'b0;
    unique case (1'b1)
      st_idle: begin
        if (in_valid) begin
          ldM     = 1'b1;
          clrA    = 1'b1;
          ldcnt   = 1'b1;
          clrQ    = 1'b1;
          state_d = S_LDQ;
        end
      end
      st_ldq: begin
        if (in_valid) begin
          ldQ     = 1'b1;
          clrff   = 1'b1;
          state_d = S_EVAL;
        end
      end
      st_eval: begin
        if (eqz) begin
          state_d = S_DONE;
        end else begin
          case ({q0, qm1})
            2'b01: begin
              ldA     = 1'b1;
              addsub  = 1'b1;
              state_d = S_SHIFT;
            end
            2'b10: begin
              ldA     = 1'b1;
              state_d = S_SHIFT;
            end
            default: begin
`ifdef BOOTH_SKIP_EN
              // nothing to add, so shift right here
              shiftA = 1'b1;
              shiftQ = 1'b1;
              decr   = 1'b1;
`else
              state_d = S_SHIFT;
`endif
            end
          endcase
        end
      end
      st_shift: begin
        shiftA  = 1'b1;
        shiftQ  = 1'b1;
        decr    = 1'b1;
        state_d = S_EVAL;
      end
      st_done: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifndef SYNTHESIS
  // shift count since ldcnt; eqz must coincide with CNT_INIT shifts
  logic [3:0] iter_q;
  logic [3:0] iter_d;

  always_comb begin
    iter_d = iter_q;
    if (ldcnt) begin
      iter_d = 4'd0;
    end else if (decr) begin
      iter_d = iter_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= 4'd0;
    end else begin
      iter_q <= iter_d;
    end
  end

  a_iter: assert property (
    @(posedge clk) disable iff (!rst_n)
    (st_eval && eqz) |-> (iter_q == CNT_INIT)
  );

  a_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0({ldA, shiftA, clrA})
  );
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: booth_ctrl driving a behavioural datapath, scoreboarded
// against signed multiplication and Booth pair counts.
module tb_booth_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic eqz;
  logic q0;
  logic qm1;
  logic ldA, shiftA, clrA;
  logic ldQ, shiftQ, clrQ;
  logic clrff, ldM, addsub;
  logic ldcnt, decr;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  booth_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .eqz       (eqz),
    .q0        (q0),
    .qm1       (qm1),
    .ldA       (ldA),
    .shiftA    (shiftA),
    .clrA      (clrA),
    .ldQ       (ldQ),
    .shiftQ    (shiftQ),
    .clrQ      (clrQ),
    .clrff     (clrff),
    .ldM       (ldM),
    .addsub    (addsub),
    .ldcnt     (ldcnt),
    .decr      (decr)
  );

  // datapath the controller is steering
  logic [7:0] dp_a = '0;
  logic [7:0] dp_q = '0;
  logic [7:0] dp_m = '0;
  logic       dp_qm1 = 1'b0;
  logic [3:0] dp_cnt = '0;

  always @(posedge clk) begin
    if (ldM) dp_m <= data_in;
    if (clrA) dp_a <= '0;
    else if (ldA) dp_a <= addsub ? dp_a + dp_m : dp_a - dp_m;
    else if (shiftA) dp_a <= {dp_a[7], dp_a[7:1]};
    if (clrQ) dp_q <= '0;
    else if (ldQ) dp_q <= data_in;
    else if (shiftQ) dp_q <= {dp_a[0], dp_q[7:1]};
    if (clrff) dp_qm1 <= 1'b0;
    else if (shiftQ) dp_qm1 <= dp_q[0];
    if (ldcnt) dp_cnt <= 4'd8;
    else if (decr) dp_cnt <= dp_cnt - 4'd1;
  end

  assign eqz = (dp_cnt == 4'd0);
  assign q0  = dp_q[0];
  assign qm1 = dp_qm1;

  logic [15:0] product;
  logic [11:0] strb;
  assign product = {dp_a, dp_q};
  assign strb = {ldA, shiftA, clrA, ldQ, shiftQ, clrQ,
                 clrff, ldM, addsub, ldcnt, decr, 1'b0};

  typedef struct {
    logic [15:0] prod;
    int lat;
    int nadd;
    int nsub;
    int acc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_hand = 0;
  bit in_flight;
  logic [7:0] cur_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] m,
                                 input logic [7:0] q,
                                 input int acc);
    exp_t e;
    logic prev;
    int same;
    logic signed [15:0] sm, sq;
    sm = {{8{m[7]}}, m};
    sq = {{8{q[7]}}, q};
    e.prod = 16'(sm * sq);
    e.nadd = 0;
    e.nsub = 0;
    e.acc = acc;
    prev = 1'b0;
    same = 0;
    for (int i = 0; i < 8; i++) begin
      if (q[i] == prev) same++;
      else if (q[i]) e.nsub++;
      else e.nadd++;
      prev = q[i];
    end
`ifdef BOOTH_SKIP_EN
    e.lat = 17 - same;
`else
    e.lat = 17;
`endif
    return e;
  endfunction

  // monitor: checks every cycle, pops at product presentation
  int n_add = 0;
  int n_sub = 0;
  bit ov_seen = 1'b0;
  logic [15:0] held;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      ov_seen = 1'b0;
    end else begin
      if (ldM) begin
        n_add = 0;
        n_sub = 0;
      end
      if (ldA) begin
        if (addsub) n_add++;
        else n_sub++;
      end
      chk("strobe_excl",
          32'($countones({ldA, shiftA, clrA}) <= 1), 1);
      if (in_flight && !out_valid) begin
        chk("run_in_ready", in_ready, 0);
        chk("run_busy", busy, 1);
        chk("run_loads",
            {ldM, ldQ, clrA, clrQ, ldcnt, clrff}, 0);
      end
      if (out_valid) begin
        chk("done_strobes", strb, 0);
        chk("done_in_ready", in_ready, 0);
        chk("done_busy", busy, 1);
        if (!ov_seen) begin
          ov_seen = 1'b1;
          held = product;
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: product %h", product);
          end else begin
            e = sb.pop_front();
            chk("product", product, e.prod);
            chk("latency", cyc - e.acc, e.lat);
            chk("n_add", n_add, e.nadd);
            chk("n_sub", n_sub, e.nsub);
          end
        end else begin
          chk("product_stable", product, held);
        end
        if (out_ready) begin
          ov_seen = 1'b0;
          n_hand++;
        end
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after acceptance
  task automatic beat(input logic [7:0] v,
                      input bit last,
                      output int w);
    bit acc;
    acc = 1'b0;
    w = 0;
    in_valid = 1'b1;
    data_in = v;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) w++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      chk("beat_accept", acc, 1);
    end else if (last) begin
      in_flight = 1'b1;
      sb.push_back(model(cur_m, v, cyc));
    end
  endtask

  task automatic run_op(input logic [7:0] m,
                        input logic [7:0] q,
                        input bit noise,
                        input bit bp);
    int w;
    int h0;
    int bpc;
    bpc = 0;
    cur_m = m;
    h0 = n_hand;
    beat(m, 1'b0, w);
    chk("m_beat_wait", w, 0);
    beat(q, 1'b1, w);
    chk("q_beat_wait", w, 0);
    for (int t = 0; t < 300 && n_hand == h0; t++) begin
      in_valid = noise && !out_valid && ($urandom_range(1) == 1);
      data_in = 8'($urandom);
      if (bp) begin
        if (out_valid) bpc++;
        out_ready = (bpc > 10);
      end else begin
        out_ready = ($urandom_range(2) != 0);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_flight = 1'b0;
    if (n_hand == h0) begin
      chk("handoff_timeout", n_hand - h0, 1);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
    if (bp) begin
      chk("bp_done_cycles", bpc, 11);
      chk("bp_after_ov", out_valid, 0);
      chk("bp_after_rdy", in_ready, 1);
    end
  endtask

  task automatic reset_mid(input logic [7:0] m, input logic [7:0] q);
    int w;
    int ns;
    ns = 0;
    cur_m = m;
    out_ready = 1'b1;
    beat(m, 1'b0, w);
    beat(q, 1'b1, w);
    for (int t = 0; t < 100 && ns < 4; t++) begin
      @(negedge clk);
      if (shiftA) ns++;
    end
    chk("rst_shift4", ns, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_strobes", strb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    in_flight = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rm;
    logic [7:0] rq;
    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    in_flight = 1'b0;
    cur_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_strobes", strb, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_strobes", strb, 0);

    run_op(8'd5, 8'd3, 1'b0, 1'b0);
    run_op(8'hF9, 8'h06, 1'b0, 1'b0);
    run_op(8'h7F, 8'h80, 1'b1, 1'b0);
    run_op(8'd3, 8'd0, 1'b0, 1'b0);
    run_op(8'h9C, 8'h5B, 1'b1, 1'b1);
    reset_mid(8'h35, 8'hA6);
    run_op(8'd2, 8'd2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rm = 8'($urandom);
      if (rm == 8'h80) rm = 8'h81;
      rq = 8'($urandom);
      run_op(rm, rq, 1'b1, ($urandom_range(7) == 0));
    end

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
